// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// prog_loader
//
// Byte-stream program loader for the RV32I core. While loading it holds the
// CPU in reset, receives a framed image over a valid/ready byte interface,
// assembles little-endian 32-bit words and writes them into instruction
// memory, then writes one argument word into a register-file entry and
// finally releases the CPU.
//
// Frame: SYNC_BYTE, CNT_LO, CNT_HI, CNT x (4 bytes, LSB first),
//        4 argument bytes (LSB first).
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte this cycle (low only while writing)
//   imem_we    instruction-memory write strobe, one cycle per word
//   imem_addr  word-aligned byte address (index*4)
//   imem_wdata assembled instruction word
//   rf_we      register-file write strobe
//   rf_addr    register index, equals ARG_REG during the write
//   rf_wdata   argument word
//   cpu_rst    active-high CPU reset; high except after a completed load
//   done       high after a successful load until the next frame starts
//   error      sticky frame error (only rst clears it)
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          ARG_REG    = 10,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam logic [3:0] S_SYNC = 4'd0;
  localparam logic [3:0] S_LEN0 = 4'd1;
  localparam logic [3:0] S_LEN1 = 4'd2;
  localparam logic [3:0] S_DATA = 4'd3;
  localparam logic [3:0] S_WR   = 4'd4;
  localparam logic [3:0] S_ARG  = 4'd5;
  localparam logic [3:0] S_RFW  = 4'd6;
  localparam logic [3:0] S_DONE = 4'd7;
  localparam logic [3:0] S_ERR  = 4'd8;

  logic [3:0]  state;
  logic [15:0] count;
  logic [15:0] idx;
  logic [1:0]  byte_k;
  logic [31:0] word;
  logic        take;
  logic [15:0] count_new;

  // Replace byte lane k of w with b (little-endian assembly).
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  k,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (k)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic count_too_big(input logic [15:0] c);
    return int'(c) > IMEM_DEPTH;
  endfunction

  assign take      = in_valid && in_ready;
  // Full count as it becomes known on the LEN1 byte.
  assign count_new = {in_data, count[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_SYNC;
      count  <= '0;
      idx    <= '0;
      byte_k <= '0;
      word   <= '0;
    end else begin
      case (state)
        S_SYNC: begin
          if (take && in_data == SYNC_BYTE) begin
            state  <= S_LEN0;
            idx    <= '0;
            byte_k <= '0;
          end
        end
        S_LEN0: begin
          if (take) begin
            count[7:0] <= in_data;
            state      <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (take) begin
            count[15:8] <= in_data;
            byte_k      <= '0;
            if (count_too_big(count_new)) begin
              state <= S_ERR;
            end else if (count_new == 16'd0) begin
              state <= S_ARG;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            word   <= put_byte(word, byte_k, in_data);
            byte_k <= byte_k + 2'd1;
            if (byte_k == 2'd3) begin
              state <= S_WR;
            end
          end
        end
        // Single write cycle; the index advances after the word is issued.
        S_WR: begin
          idx <= idx + 16'd1;
          if (idx + 16'd1 == count) begin
            state <= S_ARG;
          end else begin
            state <= S_DATA;
          end
        end
        S_ARG: begin
          if (take) begin
            word   <= put_byte(word, byte_k, in_data);
            byte_k <= byte_k + 2'd1;
            if (byte_k == 2'd3) begin
              state <= S_RFW;
            end
          end
        end
        S_RFW: begin
          state <= S_DONE;
        end
        // A new sync byte restarts loading and re-asserts CPU reset at once.
        S_DONE: begin
          if (take && in_data == SYNC_BYTE) begin
            state  <= S_LEN0;
            idx    <= '0;
            byte_k <= '0;
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_SYNC;
        end
      endcase
    end
  end

  // Outputs decode directly from state so reset reaches them asynchronously.
  always_comb begin
    in_ready   = !(state == S_WR || state == S_RFW);
    imem_we    = (state == S_WR);
    imem_addr  = '0;
    imem_wdata = '0;
    rf_we      = (state == S_RFW);
    rf_addr    = '0;
    rf_wdata   = '0;
    cpu_rst    = (state != S_DONE);
    done       = (state == S_DONE);
    error      = (state == S_ERR);
    if (state == S_WR) begin
      imem_addr  = {14'd0, idx, 2'b00};
      imem_wdata = word;
    end
    if (state == S_RFW) begin
      rf_addr  = 5'(ARG_REG);
      rf_wdata = word;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .cpu_rst(cpu_rst), .done(done), .error(error)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cycle    = 0;
  int rf_cycle = -1;
  int done_cycle = -1;
  logic prev_done = 1'b0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] got_arg[$];

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_arg;
  bit          exp_has_arg;
  bit          exp_err;

  // Observe writes and interface rules on the falling edge.
  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      if (imem_we) begin
        got_addr.push_back(imem_addr);
        got_data.push_back(imem_wdata);
      end
      if (rf_we) begin
        got_arg.push_back(rf_wdata);
        rf_cycle = cycle;
        n_checks++;
        if (rf_addr !== 5'd10) begin
          n_fails++;
          $display("FAIL rf_addr got %0d expected 10", rf_addr);
        end
      end
      n_checks++;
      if ((in_ready !== !(imem_we || rf_we)) || (imem_we && rf_we) ||
          ((imem_we || rf_we) && !cpu_rst) || (done !== !cpu_rst) ||
          (done && error)) begin
        n_fails++;
        $display("FAIL interface_rules cycle %0d got rdy=%b we=%b rfwe=%b cpu_rst=%b done=%b err=%b",
                 cycle, in_ready, imem_we, rf_we, cpu_rst, done, error);
      end
      if (done && !prev_done) done_cycle = cycle;
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] le32(input byte_q_t q, input int i);
    return {q[i+3], q[i+2], q[i+1], q[i]};
  endfunction

  // Reference: parse the first frame of a byte list into expected effects.
  task automatic model(input byte_q_t q);
    int i;
    int cnt;
    exp_addr.delete();
    exp_data.delete();
    exp_has_arg = 0;
    exp_err = 0;
    exp_arg = 0;
    i = 0;
    while (i < q.size() && q[i] != 8'hA5) i++;
    if (i + 2 >= q.size()) return;
    cnt = int'(q[i+1]) + 256 * int'(q[i+2]);
    i += 3;
    if (cnt > 256) begin
      exp_err = 1;
      return;
    end
    for (int w = 0; w < cnt; w++) begin
      exp_addr.push_back(32'(w * 4));
      exp_data.push_back(le32(q, i));
      i += 4;
    end
    exp_arg = le32(q, i);
    exp_has_arg = 1;
  endtask

  function automatic int write_mismatch();
    if (got_addr.size() != exp_addr.size())
      return (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    foreach (exp_addr[k])
      if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) return k;
    return -1;
  endfunction

  task automatic clear_got();
    got_addr.delete();
    got_data.delete();
    got_arg.delete();
    rf_cycle = -1;
    done_cycle = -1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fails++;
      $display("FAIL handshake_timeout got in_ready=0 for %0d cycles expected 1", waited);
    end
    @(posedge clk);
  endtask

  // mode 0: back-to-back, 1: every other cycle + 20-cycle gap, 2: random gaps
  task automatic send_frame(input byte_q_t q, input int mode);
    int gap;
    foreach (q[i]) begin
      case (mode)
        0:       gap = 0;
        1:       gap = (i == 9) ? 21 : 1;
        default: gap = $urandom_range(0, 2);
      endcase
      send_byte(q[i], gap);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic byte_q_t scenario1();
    byte_q_t q;
    q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h15, 8'h00,
          8'h33, 8'h05, 8'hA5, 8'h02, 8'h07, 8'h00, 8'h00, 8'h00};
    return q;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, cpu_rst} !== 2'b11) begin
      n_fails++;
      $display("FAIL reset_ready_cpu_rst got %b%b expected 11", in_ready, cpu_rst);
    end
    n_checks++;
    if ({imem_we, rf_we, done, error} !== 4'b0000 || imem_addr !== 0 ||
        imem_wdata !== 0 || rf_addr !== 0 || rf_wdata !== 0) begin
      n_fails++;
      $display("FAIL reset_outputs got we=%b rfwe=%b done=%b err=%b addr=%h expected all 0",
               imem_we, rf_we, done, error, imem_addr);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    byte_q_t q;
    int bad;
    clear_got();
    q = scenario1();
    model(q);
    send_frame(q, 0);
    n_checks++;
    bad = write_mismatch();
    if (bad >= 0 || got_data.size() != 2 || got_data[0] !== 32'h00150513 ||
        got_data[1] !== 32'h02A50533 || got_addr[1] !== 32'd4) begin
      n_fails++;
      $display("FAIL basic_writes got %0d writes first %h second %h expected 2 writes 00150513 02a50533",
               got_data.size(), got_data[0], got_data[1]);
    end
    n_checks++;
    if (got_arg.size() != 1 || got_arg[0] !== 32'd7) begin
      n_fails++;
      $display("FAIL basic_arg got %0d writes data %h expected 1 write 7", got_arg.size(), got_arg[0]);
    end
    n_checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || done_cycle != rf_cycle + 1) begin
      n_fails++;
      $display("FAIL basic_release got done=%b cpu_rst=%b done_cycle=%0d expected 1 0 %0d",
               done, cpu_rst, done_cycle, rf_cycle + 1);
    end
  endtask

  task automatic test_garbage_count0();
    byte_q_t q;
    apply_reset();
    clear_got();
    q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h2A, 8'h00, 8'h00, 8'h00};
    model(q);
    send_frame(q, 0);
    n_checks++;
    if (got_addr.size() != 0) begin
      n_fails++;
      $display("FAIL garbage_no_imem got %0d writes expected 0", got_addr.size());
    end
    n_checks++;
    if (got_arg.size() != 1 || got_arg[0] !== exp_arg || exp_arg !== 32'h2A || done !== 1'b1) begin
      n_fails++;
      $display("FAIL garbage_arg got %0d writes data %h done=%b expected 1 write 2a done=1",
               got_arg.size(), got_arg[0], done);
    end
  endtask

  task automatic test_stall();
    byte_q_t q;
    int bad;
    apply_reset();
    clear_got();
    q = scenario1();
    model(q);
    send_frame(q, 1);
    n_checks++;
    bad = write_mismatch();
    if (bad >= 0) begin
      n_fails++;
      $display("FAIL stall_writes idx %0d got %0d writes (%h) expected %0d writes (%h)",
               bad, got_addr.size(), got_data[bad], exp_addr.size(), exp_data[bad]);
    end
    n_checks++;
    if (got_arg.size() != 1 || got_arg[0] !== exp_arg || done !== 1'b1) begin
      n_fails++;
      $display("FAIL stall_arg got %0d writes data %h done=%b expected 1 write %h done=1",
               got_arg.size(), got_arg[0], done, exp_arg);
    end
  endtask

  task automatic test_overflow();
    byte_q_t q;
    int bad;
    apply_reset();
    clear_got();
    q = '{8'hA5, 8'h01, 8'h01};
    model(q);
    send_frame(q, 0);
    n_checks++;
    if (error !== exp_err || exp_err !== 1'b1 || cpu_rst !== 1'b1) begin
      n_fails++;
      $display("FAIL overflow_error got error=%b cpu_rst=%b expected 1 1", error, cpu_rst);
    end
    send_frame(scenario1(), 0);
    n_checks++;
    if (got_addr.size() != 0 || got_arg.size() != 0 || error !== 1'b1 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL overflow_sticky got %0d/%0d writes error=%b done=%b expected 0/0 1 0",
               got_addr.size(), got_arg.size(), error, done);
    end
    apply_reset();
    clear_got();
    q = scenario1();
    model(q);
    send_frame(q, 0);
    n_checks++;
    bad = write_mismatch();
    if (bad >= 0 || error !== 1'b0 || done !== 1'b1) begin
      n_fails++;
      $display("FAIL overflow_recover idx %0d got %0d writes error=%b done=%b expected %0d writes 0 1",
               bad, got_addr.size(), error, done, exp_addr.size());
    end
  endtask

  task automatic test_full_depth();
    byte_q_t q;
    int bad;
    apply_reset();
    clear_got();
    q = '{8'hA5, 8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      q.push_back(8'(i));
      q.push_back(8'h00);
      q.push_back(8'h00);
      q.push_back(8'h00);
    end
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom_range(0, 255)));
    model(q);
    send_frame(q, 0);
    n_checks++;
    bad = write_mismatch();
    if (bad >= 0) begin
      n_fails++;
      $display("FAIL full_writes idx %0d got %0d writes (%h) expected %0d writes (%h)",
               bad, got_addr.size(), got_data[bad], exp_addr.size(), exp_data[bad]);
    end
    n_checks++;
    if (got_addr.size() != 256 || got_addr[255] !== 32'h3FC || got_data[255] !== 32'hFF ||
        done !== 1'b1) begin
      n_fails++;
      $display("FAIL full_last got %0d writes last addr %h data %h done=%b expected 256 3fc ff 1",
               got_addr.size(), got_addr[255], got_data[255], done);
    end
  endtask

  task automatic test_abort_reload();
    byte_q_t q;
    int bad;
    apply_reset();
    clear_got();
    q = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    foreach (q[i]) send_byte(q[i], 0);
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, cpu_rst, imem_we, rf_we, done, error} !== 6'b110000 || imem_addr !== 0) begin
      n_fails++;
      $display("FAIL abort_async got rdy=%b cpu_rst=%b we=%b rfwe=%b done=%b err=%b expected 110000",
               in_ready, cpu_rst, imem_we, rf_we, done, error);
    end
    n_checks++;
    if (got_addr.size() != 2 || got_data[0] !== 32'h44332211 || got_data[1] !== 32'h88776655) begin
      n_fails++;
      $display("FAIL abort_prior_writes got %0d writes %h %h expected 2 44332211 88776655",
               got_addr.size(), got_data[0], got_data[1]);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_got();
    q = scenario1();
    model(q);
    send_frame(q, 0);
    n_checks++;
    bad = write_mismatch();
    if (bad >= 0 || done !== 1'b1) begin
      n_fails++;
      $display("FAIL abort_reload idx %0d got %0d writes done=%b expected %0d writes done=1",
               bad, got_addr.size(), done, exp_addr.size());
    end
    send_byte(8'hA5, 0);
    #1;
    n_checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0) begin
      n_fails++;
      $display("FAIL restart_edge got cpu_rst=%b done=%b expected 1 0", cpu_rst, done);
    end
    in_valid = 1'b0;
  endtask

  // Back-to-back random frames with leading garbage, restarted from DONE.
  task automatic test_back_to_back();
    byte_q_t q;
    int bad;
    int cnt;
    logic [7:0] g;
    apply_reset();
    for (int it = 0; it < 5; it++) begin
      clear_got();
      q.delete();
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        g = 8'($urandom_range(0, 255));
        q.push_back((g == 8'hA5) ? 8'h00 : g);
      end
      cnt = $urandom_range(1, 7);
      q.push_back(8'hA5);
      q.push_back(8'(cnt));
      q.push_back(8'h00);
      for (int j = 0; j < 4 * cnt + 4; j++) q.push_back(8'($urandom_range(0, 255)));
      model(q);
      send_frame(q, 2);
      n_checks++;
      bad = write_mismatch();
      if (bad >= 0) begin
        n_fails++;
        $display("FAIL random_writes frame %0d idx %0d got %0d writes (%h) expected %0d writes (%h)",
                 it, bad, got_addr.size(), got_data[bad], exp_addr.size(), exp_data[bad]);
      end
      n_checks++;
      if (got_arg.size() != 1 || got_arg[0] !== exp_arg || done !== 1'b1) begin
        n_fails++;
        $display("FAIL random_arg frame %0d got %0d writes %h done=%b expected 1 write %h done=1",
                 it, got_arg.size(), got_arg[0], done, exp_arg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_garbage_count0();
    test_stall();
    test_overflow();
    test_full_depth();
    test_abort_reload();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
